mem_stage: RTL and testbench

//  MIPS32 memory-access stage, directly downstream of EX. Consumes the EX ALU result
//  as address or pass-through data, plus the rt store data and the MEM/WB controls.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/data_mem.sv | 24 ++
 rtl/mem_stage.sv | 128 ++++++++++++
 tb/tb_mem_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and widths used by the memory-access stage.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {MEM_IDLE, MEM_BUSY} mem_state_t;

  // Everything a load/store needs once it has been accepted from EX.
  typedef struct packed {
    logic [WORD_W-1:0]     alu;
    logic [WORD_W-1:0]     data;
    logic [REG_ADDR_W-1:0] dst;
    logic                  read;
    logic                  write;
    logic                  memtoreg;
    logic                  regwrite;
  } mem_req_t;

  function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read.
module data_mem
  import mips_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // NOTE: the storage array is deliberately left out of reset; contents must
  // survive a pipeline reset and a reset port would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS32 MEM stage: word loads/stores with programmable wait states and a
// registered MEM/WB bundle; stalls upstream while an access is in flight.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [WORD_W-1:0]     aluOut,
  input  logic [WORD_W-1:0]     storeData,
  input  logic [REG_ADDR_W-1:0] writeReg,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  MemtoReg,
  input  logic                  RegWrite,
  output logic                  stall_out,
  output logic                  valid_out,
  output logic [WORD_W-1:0]     wbData,
  output logic [REG_ADDR_W-1:0] wbReg,
  output logic                  wbRegWrite,
  output logic                  misalign_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);

  mem_state_t        state_q;
  logic [CW-1:0]     cnt_q;
  mem_req_t          req_q;

  mem_req_t          req_in;
  mem_req_t          req_act;
  logic              is_mem_op;
  logic              fault;
  logic              mem_go;
  logic              done_now;
  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic [WORD_W-1:0] rdata;
  logic [WORD_W-1:0] wb_data_d;

  assign req_in = '{alu: aluOut, data: storeData, dst: writeReg, read: MemRead,
                    write: MemWrite, memtoreg: MemtoReg, regwrite: RegWrite};

  assign is_mem_op = MemRead | MemWrite;
  assign fault     = (state_q == MEM_IDLE) && valid_in && is_mem_op && !is_word_aligned(aluOut);
  assign mem_go    = (state_q == MEM_IDLE) && valid_in && is_mem_op && is_word_aligned(aluOut);

  // With zero wait states the access uses the live EX inputs; otherwise the captured request.
  assign done_now  = (mem_go && (WAIT_CYCLES == 0)) ||
                     ((state_q == MEM_BUSY) && (cnt_q == CW'(1)));
  assign req_act   = (state_q == MEM_BUSY) ? req_q : req_in;
  assign mem_addr  = req_act.alu[AW+1:2];
  assign mem_we    = done_now && req_act.write;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    wb_data_d = req_act.alu;
    if (req_act.read && !req_act.write && req_act.memtoreg) wb_data_d = rdata;
  end

  data_mem #(.DEPTH(DEPTH)) u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (req_act.data),
    .rdata (rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MEM_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      stall_out    <= 1'b0;
      valid_out    <= 1'b0;
      wbData       <= '0;
      wbReg        <= '0;
      wbRegWrite   <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      valid_out    <= 1'b0;
      misalign_err <= 1'b0;
      case (state_q)
        MEM_IDLE: begin
          if (valid_in) begin
            if (fault) begin
              valid_out    <= 1'b1;
              misalign_err <= 1'b1;
              wbData       <= aluOut;
              wbReg        <= writeReg;
              wbRegWrite   <= 1'b0;
            end else if (!is_mem_op || (WAIT_CYCLES == 0)) begin
              valid_out    <= 1'b1;
              wbData       <= wb_data_d;
              wbReg        <= writeReg;
              wbRegWrite   <= RegWrite;
            end else begin
              state_q      <= MEM_BUSY;
              cnt_q        <= CNT_INIT;
              req_q        <= req_in;
              stall_out    <= 1'b1;
            end
          end
        end
        MEM_BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q    <= MEM_IDLE;
            stall_out  <= 1'b0;
            valid_out  <= 1'b1;
            wbData     <= wb_data_d;
            wbReg      <= req_q.dst;
            wbRegWrite <= req_q.regwrite;
          end
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage: a cycle-indexed transaction model predicts
// every output each cycle; directed literal checks pin the model.
module tb_mem_stage;
  import mips_pkg::*;

  localparam int DEPTH = 256;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] aluOut = '0;
  logic [31:0] storeData = '0;
  logic [4:0]  writeReg = '0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, MemtoReg = 1'b0, RegWrite = 1'b0;
  logic        stall_out, valid_out, wbRegWrite, misalign_err;
  logic [31:0] wbData;
  logic [4:0]  wbReg;

  mem_stage #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .aluOut(aluOut),
    .storeData(storeData), .writeReg(writeReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .stall_out(stall_out), .valid_out(valid_out), .wbData(wbData),
    .wbReg(wbReg), .wbRegWrite(wbRegWrite), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one record per accepted request, due on the cycle its result shows.
  typedef struct {
    int          due;
    bit          mis;
    bit          ld;
    bit          st;
    int          idx;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  dst;
    bit          rw;
  } ev_t;

  ev_t         evq[$];
  logic [31:0] mem_m [DEPTH];
  int          free_cyc = 0;
  int          stall_lo = -1;
  int          stall_hi = -2;

  ev_t         e;
  logic [31:0] exp_data;
  logic [31:0] h_data;
  logic [4:0]  h_reg;
  logic        h_rw;
  bit          h_known = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid_out", valid_out, 0);
      check("rst_stall_out", stall_out, 0);
      check("rst_misalign", misalign_err, 0);
      check("rst_wbData", wbData, 0);
      check("rst_wbReg", wbReg, 0);
      check("rst_wbRegWrite", wbRegWrite, 0);
      h_data = '0; h_reg = '0; h_rw = 1'b0; h_known = 1'b1;
    end else begin
      check("stall_out", stall_out, (cyc >= stall_lo && cyc <= stall_hi) ? 1 : 0);
      if (evq.size() > 0 && evq[0].due == cyc) begin
        e = evq.pop_front();
        check("valid_out", valid_out, 1);
        check("misalign_err", misalign_err, e.mis);
        check("wbRegWrite", wbRegWrite, e.rw);
        h_rw = e.rw;
        if (e.mis) begin
          h_known = 1'b0;
        end else begin
          exp_data = e.ld ? mem_m[e.idx] : e.alu;
          check("wbData", wbData, exp_data);
          check("wbReg", wbReg, e.dst);
          if (e.st) mem_m[e.idx] = e.sd;
          h_data = exp_data; h_reg = e.dst; h_known = 1'b1;
        end
      end else begin
        check("valid_out_idle", valid_out, 0);
        check("misalign_idle", misalign_err, 0);
        check("wbRegWrite_hold", wbRegWrite, h_rw);
        if (h_known) begin
          check("wbData_hold", wbData, h_data);
          check("wbReg_hold", wbReg, h_reg);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    next_cycle();
    valid_in = 1'b0;
    aluOut = $urandom; storeData = $urandom; writeReg = 5'($urandom);
    MemRead = 1'($urandom); MemWrite = 1'($urandom);
    MemtoReg = 1'($urandom); RegWrite = 1'($urandom);
  endtask

  // Presents one request on the first cycle the model considers the stage free;
  // while busy, inputs are scrambled since the stage must ignore them.
  task automatic present(input logic [31:0] a, input logic [31:0] sd, input logic [4:0] d,
                         input bit mr, input bit mw, input bit m2r, input bit rwr);
    bit is_mem, mis;
    ev_t ev;
    next_cycle();
    while (cyc < free_cyc) begin
      valid_in = 1'($urandom); aluOut = $urandom; storeData = $urandom;
      writeReg = 5'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
      next_cycle();
    end
    valid_in = 1'b1; aluOut = a; storeData = sd; writeReg = d;
    MemRead = mr; MemWrite = mw; MemtoReg = m2r; RegWrite = rwr;
    is_mem = mr || mw;
    mis    = is_mem && (a % 4 != 0);
    if (is_mem && !mis && W > 0) begin
      stall_lo = cyc + 1;
      stall_hi = cyc + W;
      ev.due   = cyc + W + 1;
    end else begin
      ev.due   = cyc + 1;
    end
    free_cyc = ev.due;
    ev.mis = mis;
    ev.st  = mw && !mis;
    ev.ld  = mr && !mw && m2r && !mis;
    ev.idx = int'((a >> 2) % DEPTH);
    ev.alu = a; ev.sd = sd; ev.dst = d;
    ev.rw  = rwr && !mis;
    evq.push_back(ev);
  endtask

  task automatic await_valid(input string name);
    int n;
    n = 0;
    do begin
      idle();
      n++;
    end while (valid_out !== 1'b1 && n < W + 3);
    check({name, "_valid"}, valid_out, 1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    evq.delete();
    free_cyc = 0; stall_lo = -1; stall_hi = -2;
    valid_in = 1'b0;
    repeat (n) next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);

    // ALU pass-through: result one cycle later, no stall.
    present(32'h0000_0010, 32'h0, 5'd5, 0, 0, 0, 1);
    idle();
    check("alu_valid", valid_out, 1);
    check("alu_wbData", wbData, 32'h10);
    check("alu_wbReg", wbReg, 5);
    check("alu_wbRegWrite", wbRegWrite, 1);
    check("alu_stall", stall_out, 0);

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) present(32'(i * 4), $urandom, 5'd0, 0, 1, 0, 0);
    present(32'h10, 32'hDEAD_BEEF, 5'd0, 0, 1, 0, 0);

    // SW then back-to-back LW at 0x20.
    present(32'h20, 32'hCAFE_F00D, 5'd0, 0, 1, 0, 0);
    idle(); check("sw_stall_c1", stall_out, 1);
    idle(); check("sw_stall_c2", stall_out, 1);
    idle(); check("sw_stall_c3", stall_out, 0);
    check("sw_valid", valid_out, 1);
    present(32'h20, 32'h0, 5'd7, 1, 0, 1, 1);
    idle(); check("lw_stall_c1", stall_out, 1);
    idle(); check("lw_stall_c2", stall_out, 1);
    idle(); check("lw_valid", valid_out, 1);
    check("lw_wbData", wbData, 32'hCAFE_F00D);
    check("lw_wbReg", wbReg, 7);

    // Misaligned load.
    present(32'h22, 32'h0, 5'd9, 1, 0, 1, 1);
    idle();
    check("mis_valid", valid_out, 1);
    check("mis_err", misalign_err, 1);
    check("mis_wbRegWrite", wbRegWrite, 0);
    check("mis_stall", stall_out, 0);

    // Reset during BUSY cycle 1 discards the store.
    present(32'h20, 32'h1234_5678, 5'd0, 0, 1, 0, 0);
    next_cycle();
    valid_in = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_busy_valid", valid_out, 0);
    check("rst_busy_stall", stall_out, 0);
    do_reset(2);
    repeat (4) idle();
    present(32'h20, 32'h0, 5'd3, 1, 0, 1, 1);
    await_valid("rst_lw");
    check("rst_lw_wbData", wbData, 32'hCAFE_F00D);
    present(32'h10, 32'h0, 5'd4, 1, 0, 1, 1);
    await_valid("beef_lw");
    check("beef_lw_wbData", wbData, 32'hDEAD_BEEF);

    // Address wrap modulo DEPTH*4.
    present(32'h400, 32'hA5A5_1234, 5'd0, 0, 1, 0, 0);
    present(32'h000, 32'h0, 5'd8, 1, 0, 1, 1);
    await_valid("wrap_lw");
    check("wrap_lw_wbData", wbData, 32'hA5A5_1234);

    // MemRead and MemWrite together behave as a store returning aluOut.
    present(32'h30, 32'h0000_0055, 5'd2, 1, 1, 1, 1);
    await_valid("both");
    check("both_wbData", wbData, 32'h30);
    present(32'h30, 32'h0, 5'd2, 1, 0, 1, 1);
    await_valid("both_lw");
    check("both_lw_wbData", wbData, 32'h55);

    // Random mix; the per-cycle model does the checking.
    for (int t = 0; t < 400; t++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 2) == 0) a[31:10] = '0;
      case (kind)
        0: present(a, $urandom, 5'($urandom), 0, 0, 0, 1'($urandom));
        1: present(a, $urandom, 5'($urandom), 1, 0, 1'($urandom), 1'($urandom));
        2: present(a, $urandom, 5'($urandom), 0, 1, 0, 1'($urandom));
        default: present(a, $urandom, 5'($urandom), 1, 1, 1'($urandom), 1'($urandom));
      endcase
      if ($urandom_range(0, 3) == 0) idle();
    end

    repeat (W + 4) idle();
    check("drain_pending", evq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
